// File: rtl/operand_block_server_pkg.sv
// Shared types and constants for operand_block_server.
// Module-level widths are derived from each instance's parameters using
// the helpers here. The constants below describe the default 4096-bit
// configuration.
package operand_block_server_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } load_state_e;

  localparam int DEFAULT_REGISTER_SIZE = 32;
  localparam int DEFAULT_NUM_BLOCKS    = 128;
  localparam int DEFAULT_NUM_CHANNELS  = 3;

  // Counter width that stays at least one bit wide for tiny ranges.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int BYTES_PER_BLOCK = DEFAULT_REGISTER_SIZE / 8;
  localparam int IDX_W           = $clog2(DEFAULT_NUM_BLOCKS);
  localparam int CH_W            = $clog2(DEFAULT_NUM_CHANNELS);

endpackage

// File: rtl/operand_block_server_read_channel.sv
// block_read_channel: one read port's block index, wrap pulse and the
// restart-over-consume priority. Exposes the next index so the parent can
// register the matching memory word on the same edge.
module block_read_channel #(
  parameter int NUM_BLOCKS = 128
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          ready_in,
  input  logic                          consume_in,
  input  logic                          restart_in,
  input  logic                          clear_in,
  output logic [$clog2(NUM_BLOCKS)-1:0] index_d_out,
  output logic [$clog2(NUM_BLOCKS)-1:0] index_out,
  output logic                          wrap_out
);

  localparam int IW = $clog2(NUM_BLOCKS);

  logic [IW-1:0] idx_q, idx_d;
  logic          wrap_q, wrap_d;

  // Next index: restart/load-clear beat consume; consume only when loaded.
  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
    if (restart_in || clear_in) begin
      idx_d = '0;
    end else if (consume_in && ready_in) begin
      if (idx_q == IW'(NUM_BLOCKS - 1)) begin
        idx_d  = '0;
        wrap_d = 1'b1;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  // Index and wrap registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      idx_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      wrap_q <= wrap_d;
    end
  end

  assign index_d_out = idx_d;
  assign index_out   = idx_q;
  assign wrap_out    = wrap_q;

endmodule

// File: rtl/operand_block_server.sv
// operand_block_server: multi-channel operand store. A byte-stream load
// port fills one channel's operand (LSB-first); each read channel serves
// its operand one block at a time with consume/restart and wrap-around.
// Optional per-channel XOR checksum of the last load:
// `define OPERAND_BLOCK_SERVER_CHECKSUM_EN
module operand_block_server
  import operand_block_server_pkg::*;
#(
  parameter int REGISTER_SIZE = DEFAULT_REGISTER_SIZE,
  parameter int NUM_BLOCKS    = DEFAULT_NUM_BLOCKS,
  parameter int NUM_CHANNELS  = DEFAULT_NUM_CHANNELS
) (
  input  logic                                      clk_in,
  input  logic                                      rst_in,
  input  logic                                      load_start_in,
  input  logic [$clog2(NUM_CHANNELS)-1:0]           load_sel_in,
  input  logic                                      load_valid_in,
  input  logic [7:0]                                load_byte_in,
  output logic                                      load_busy_out,
  output logic [NUM_CHANNELS-1:0]                   ready_out,
  input  logic [NUM_CHANNELS-1:0]                   consume_in,
  input  logic [NUM_CHANNELS-1:0]                   restart_in,
  output logic [NUM_CHANNELS*REGISTER_SIZE-1:0]     data_out,
  output logic [NUM_CHANNELS*$clog2(NUM_BLOCKS)-1:0] index_out,
  output logic [NUM_CHANNELS-1:0]                   wrap_out
`ifdef OPERAND_BLOCK_SERVER_CHECKSUM_EN
  ,
  output logic [NUM_CHANNELS*REGISTER_SIZE-1:0]     checksum_out
`endif
);

  localparam int RS  = REGISTER_SIZE;
  localparam int BPB = REGISTER_SIZE / 8;
  localparam int IW  = $clog2(NUM_BLOCKS);
  localparam int CW  = $clog2(NUM_CHANNELS);
  localparam int BW  = clog2_min1(BPB);

  load_state_e           state_q, state_d;
  logic [CW-1:0]         sel_q, sel_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic [IW-1:0]         wptr_q, wptr_d;
  logic [RS-1:0]         asm_q, asm_d;
  logic [NUM_CHANNELS-1:0] ready_q, ready_d;
  logic [NUM_CHANNELS-1:0] clear_ch;
  logic                  start_ok;
  logic                  wr_en;
  logic [RS-1:0]         wr_data;

  logic [RS-1:0] mem [NUM_CHANNELS][NUM_BLOCKS];

  assign start_ok = load_start_in && (32'(load_sel_in) < NUM_CHANNELS);

  // Load FSM: start (re)arms a channel; bytes assemble into words that are
  // written as each word completes; the final word marks the channel ready.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    bcnt_d   = bcnt_q;
    wptr_d   = wptr_q;
    asm_d    = asm_q;
    ready_d  = ready_q;
    clear_ch = '0;
    wr_en    = 1'b0;
    wr_data  = asm_q;
    if (start_ok) begin
      state_d              = LOAD;
      sel_d                = load_sel_in;
      bcnt_d               = '0;
      wptr_d               = '0;
      ready_d[load_sel_in] = 1'b0;
      clear_ch[load_sel_in] = 1'b1;
    end else if (state_q == LOAD && load_valid_in) begin
      asm_d[int'(bcnt_q)*8 +: 8] = load_byte_in;
      if (bcnt_q == BW'(BPB - 1)) begin
        wr_en   = 1'b1;
        wr_data = asm_d;
        bcnt_d  = '0;
        wptr_d  = wptr_q + IW'(1);
        if (wptr_q == IW'(NUM_BLOCKS - 1)) begin
          state_d        = IDLE;
          ready_d[sel_q] = 1'b1;
        end
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end
  end

  // Load FSM and ready registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      sel_q   <= '0;
      bcnt_q  <= '0;
      wptr_q  <= '0;
      asm_q   <= '0;
      ready_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      bcnt_q  <= bcnt_d;
      wptr_q  <= wptr_d;
      asm_q   <= asm_d;
      ready_q <= ready_d;
    end
  end

  // Operand memory: contents survive reset.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem[sel_q][wptr_q] <= wr_data;
    end
  end

  assign load_busy_out = (state_q == LOAD);
  assign ready_out     = ready_q;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    logic [IW-1:0] idx_d, idx_q;
    logic [RS-1:0] data_d, data_q;
    logic          wrap;

    block_read_channel #(
      .NUM_BLOCKS(NUM_BLOCKS)
    ) u_chan (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .ready_in    (ready_q[c]),
      .consume_in  (consume_in[c]),
      .restart_in  (restart_in[c]),
      .clear_in    (clear_ch[c]),
      .index_d_out (idx_d),
      .index_out   (idx_q),
      .wrap_out    (wrap)
    );

    // Word at the next index; a word being written there this edge is
    // forwarded so data_out never lags the memory.
    always_comb begin
      data_d = mem[c][idx_d];
      if (wr_en && sel_q == CW'(c) && wptr_q == idx_d) begin
        data_d = wr_data;
      end
    end

    // Registered block output.
    always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
        data_q <= '0;
      end else begin
        data_q <= data_d;
      end
    end

    assign data_out[c*RS +: RS]  = data_q;
    assign index_out[c*IW +: IW] = idx_q;
    assign wrap_out[c]           = wrap;
  end

`ifdef OPERAND_BLOCK_SERVER_CHECKSUM_EN
  logic [RS-1:0] csum_q [NUM_CHANNELS];
  logic [RS-1:0] csum_d [NUM_CHANNELS];

  // Running XOR of the words written by the current load of each channel.
  always_comb begin
    csum_d = csum_q;
    if (start_ok) begin
      csum_d[load_sel_in] = '0;
    end else if (wr_en) begin
      csum_d[sel_q] = csum_q[sel_q] ^ wr_data;
    end
  end

  // Checksum registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        csum_q[i] <= '0;
      end
    end else begin
      csum_q <= csum_d;
    end
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_csum
    assign checksum_out[c*RS +: RS] = csum_q[c];
  end
`endif

endmodule

// File: tb/tb_operand_block_server.sv
// Bench for operand_block_server (REGISTER_SIZE=32, NUM_BLOCKS=4,
// NUM_CHANNELS=3): byte-list model of the operand store checked every
// cycle, plus literal expectations at key points of the directed scenarios.
module tb_operand_block_server;

  localparam int RS = 32;
  localparam int NB = 4;
  localparam int NC = 3;
  localparam int IW = 2;

  logic              clk;
  logic              rst_n;
  logic              load_start;
  logic [1:0]        load_sel;
  logic              load_valid;
  logic [7:0]        load_byte;
  logic              load_busy;
  logic [NC-1:0]     ready;
  logic [NC-1:0]     consume;
  logic [NC-1:0]     restart;
  logic [NC*RS-1:0]  data;
  logic [NC*IW-1:0]  index;
  logic [NC-1:0]     wrap;

  int n_checks = 0;
  int n_fail   = 0;

  operand_block_server #(
    .REGISTER_SIZE(RS),
    .NUM_BLOCKS   (NB),
    .NUM_CHANNELS (NC)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst_n),
    .load_start_in (load_start),
    .load_sel_in   (load_sel),
    .load_valid_in (load_valid),
    .load_byte_in  (load_byte),
    .load_busy_out (load_busy),
    .ready_out     (ready),
    .consume_in    (consume),
    .restart_in    (restart),
    .data_out      (data),
    .index_out     (index),
    .wrap_out      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Model state: operand words per channel, block position, readiness.
  logic [31:0] m_mem   [NC][NB];
  bit          m_known [NC][NB];
  int          m_idx   [NC];
  bit [NC-1:0] m_ready;
  bit [NC-1:0] m_wrap;
  bit          m_busy;
  bit          m_dvalid;
  int          m_lch;
  int          m_n;
  logic [7:0]  m_buf [NB*4];
  bit          m_sok;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int c = 0; c < NC; c++) m_idx[c] = 0;
        m_ready  = '0;
        m_wrap   = '0;
        m_busy   = 1'b0;
        m_dvalid = 1'b0;
      end else begin
        m_sok = load_start && (load_sel < NC);
        for (int c = 0; c < NC; c++) begin
          m_wrap[c] = 1'b0;
          if (restart[c] || (m_sok && int'(load_sel) == c)) begin
            m_idx[c] = 0;
          end else if (consume[c] && m_ready[c]) begin
            m_idx[c] = m_idx[c] + 1;
            if (m_idx[c] == NB) begin
              m_idx[c]  = 0;
              m_wrap[c] = 1'b1;
            end
          end
        end
        if (m_sok) begin
          m_busy = 1'b1;
          m_lch  = int'(load_sel);
          m_ready[m_lch] = 1'b0;
          m_n = 0;
        end else if (m_busy && load_valid) begin
          m_buf[m_n] = load_byte;
          m_n++;
          if (m_n % 4 == 0) begin
            m_mem[m_lch][m_n/4 - 1] = {m_buf[m_n-1], m_buf[m_n-2], m_buf[m_n-3], m_buf[m_n-4]};
            m_known[m_lch][m_n/4 - 1] = 1'b1;
          end
          if (m_n == NB*4) begin
            m_busy = 1'b0;
            m_ready[m_lch] = 1'b1;
          end
        end
        m_dvalid = 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("busy", {31'd0, load_busy}, {31'd0, m_busy});
      chk("ready", {29'd0, ready}, {29'd0, m_ready});
      for (int c = 0; c < NC; c++) begin
        chk($sformatf("index_ch%0d", c), {30'd0, index[c*IW +: IW]}, 32'(m_idx[c]));
        chk($sformatf("wrap_ch%0d", c), {31'd0, wrap[c]}, {31'd0, m_wrap[c]});
        if (!m_dvalid)
          chk($sformatf("data_rst_ch%0d", c), data[c*RS +: RS], 32'h0);
        else if (m_known[c][m_idx[c]])
          chk($sformatf("data_ch%0d", c), data[c*RS +: RS], m_mem[c][m_idx[c]]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_steps [4];

  initial begin
    exp_steps[0] = 32'h07060504;
    exp_steps[1] = 32'h0B0A0908;
    exp_steps[2] = 32'h0F0E0D0C;
    exp_steps[3] = 32'h03020100;

    rst_n = 1'b1; load_start = 1'b0; load_sel = '0; load_valid = 1'b0;
    load_byte = '0; consume = '0; restart = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Bytes while idle and an out-of-range channel select are both ignored.
    load_valid = 1'b1; load_byte = 8'hEE; cyc(); load_valid = 1'b0;
    load_start = 1'b1; load_sel = 2'd3; cyc(); load_start = 1'b0;
    @(negedge clk); chk("bad_sel_busy", {31'd0, load_busy}, 32'd0);

    // Full load of channel 1 with bytes 0x00..0x0F.
    load_start = 1'b1; load_sel = 2'd1; cyc(); load_start = 1'b0;
    @(negedge clk); chk("load_busy", {31'd0, load_busy}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      load_valid = 1'b1; load_byte = 8'(i); cyc();
    end
    load_valid = 1'b0;
    @(negedge clk);
    chk("load_ready", {29'd0, ready}, 32'b010);
    chk("load_data0", data[1*RS +: RS], 32'h03020100);

    // Four consumes step through the operand and wrap once.
    for (int i = 0; i < 4; i++) begin
      consume = 3'b010; cyc(); consume = '0;
      @(negedge clk);
      chk($sformatf("step_data%0d", i), data[1*RS +: RS], exp_steps[i]);
      chk($sformatf("step_wrap%0d", i), {31'd0, wrap[1]}, (i == 3) ? 32'd1 : 32'd0);
    end

    // Restart beats consume at index 2.
    consume = 3'b010; cyc(); cyc();
    restart = 3'b010; cyc(); consume = '0; restart = '0;
    @(negedge clk);
    chk("restart_idx", {30'd0, index[1*IW +: IW]}, 32'd0);
    chk("restart_wrap", {31'd0, wrap[1]}, 32'd0);
    chk("restart_data", data[1*RS +: RS], 32'h03020100);

    // Consume on the unloaded channel 0 has no effect.
    consume = 3'b001; repeat (3) cyc(); consume = '0;
    @(negedge clk);
    chk("unloaded_idx", {30'd0, index[0 +: IW]}, 32'd0);
    chk("unloaded_wrap", {31'd0, wrap[0]}, 32'd0);

    // Aborted load of channel 2, then channel 0 while channel 1 is read.
    load_start = 1'b1; load_sel = 2'd2; cyc(); load_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      load_valid = 1'b1; load_byte = 8'(8'h50 + i); cyc();
    end
    load_start = 1'b1; load_sel = 2'd0; load_valid = 1'b1; load_byte = 8'hAA; cyc();
    load_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      load_valid = 1'b1; load_byte = 8'(8'h10 + i);
      consume = (i < 5) ? 3'b010 : 3'b000;
      cyc();
    end
    load_valid = 1'b0; consume = '0;
    @(negedge clk);
    chk("abort_ready", {29'd0, ready}, 32'b011);
    chk("abort_data_ch0", data[0 +: RS], 32'h13121110);
    chk("abort_idx_ch1", {30'd0, index[1*IW +: IW]}, 32'd1);

    // Reset in the middle of a load clears busy/ready without a clock edge.
    load_start = 1'b1; load_sel = 2'd1; cyc(); load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1; load_byte = 8'(8'h30 + i); cyc();
    end
    load_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_busy", {31'd0, load_busy}, 32'd0);
    chk("async_ready", {29'd0, ready}, 32'd0);
    chk("async_data_ch1", data[1*RS +: RS], 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // A fresh full load afterwards succeeds.
    load_start = 1'b1; load_sel = 2'd2; cyc(); load_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      load_valid = 1'b1; load_byte = 8'(8'h20 + i); cyc();
    end
    load_valid = 1'b0;
    @(negedge clk);
    chk("fresh_ready", {29'd0, ready}, 32'b100);
    chk("fresh_data", data[2*RS +: RS], 32'h23222120);
    consume = 3'b100; cyc(); consume = '0;
    @(negedge clk);
    chk("fresh_step", data[2*RS +: RS], 32'h27262524);

    repeat (3) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
